// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM encoding, writeback source
// selects and the MEM/WB payload carried to writeback.
package mem_stage_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned REG_W  = 3;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  // Writeback source selects, decoded by the writeback stage
  localparam logic [SEL_W-1:0] SRC_ALU = 3'd0;
  localparam logic [SEL_W-1:0] SRC_MEM = 3'd1;
  localparam logic [SEL_W-1:0] SRC_SET = 3'd2;
  localparam logic [SEL_W-1:0] SRC_PC  = 3'd3;

  typedef struct packed {
    logic              regWrt;
    logic [SEL_W-1:0]  regWrtSrc;
    logic [REG_W-1:0]  writeReg;
    logic [DATA_W-1:0] aluOut;
    logic [DATA_W-1:0] memData;
    logic [DATA_W-1:0] setVal;
    logic [DATA_W-1:0] nextPc;
    logic              halt;
    logic              err;
  } memWbT;

  // A bubble retires nothing: no write, no halt, no error
  localparam memWbT MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register bank; bubble overrides load, otherwise holds.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  bubble,
  input  memWbT d,
  output memWbT q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (bubble) begin
      q <= MEM_WB_BUBBLE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: data-memory request/stall/done handshake with a bounded wait,
// upstream stall generation and the MEM/WB register feeding writeback.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] aluOut,
  input  logic [DATA_W-1:0] reg2Data,
  input  logic              memEn,
  input  logic              memWrt,
  input  logic              regWrt,
  input  logic [SEL_W-1:0]  regWrtSrc,
  input  logic [REG_W-1:0]  writeReg,
  input  logic [DATA_W-1:0] setVal,
  input  logic [DATA_W-1:0] nextPc,
  input  logic              halt,
  input  logic              err,
  output logic              memReq,
  output logic              memWe,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWrData,
  input  logic [DATA_W-1:0] memRdData,
  input  logic              memStall,
  input  logic              memDone,
  output logic              stallOut,
  output logic              wbRegWrt,
  output logic [SEL_W-1:0]  wbRegWrtSrc,
  output logic [REG_W-1:0]  wbWriteReg,
  output logic [DATA_W-1:0] wbAluOut,
  output logic [DATA_W-1:0] wbMemData,
  output logic [DATA_W-1:0] wbSetVal,
  output logic [DATA_W-1:0] wbNextPc,
  output logic              wbHalt,
  output logic              wbErr
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [0:0]       stateQ, stateD;
  logic [CNT_W-1:0] countQ, countD;
  logic             misaligned;
  logic             retire;
  memWbT            wbD;
  memWbT            wbQ;

  assign misaligned = memEn & aluOut[0];

  // State and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= IDLE;
      countQ <= '0;
    end else begin
      stateQ <= stateD;
      countQ <= countD;
    end
  end

  // Next state, handshake and retire decision
  always_comb begin
    stateD   = stateQ;
    countD   = countQ;
    memReq   = 1'b0;
    stallOut = 1'b0;
    retire   = 1'b0;
    wbD      = '{regWrt:    regWrt,
                 regWrtSrc: regWrtSrc,
                 writeReg:  writeReg,
                 aluOut:    aluOut,
                 memData:   '0,
                 setVal:    setVal,
                 nextPc:    nextPc,
                 halt:      halt,
                 err:       err};

    case (stateQ)
      IDLE: begin
        if (!memEn) begin
          retire = 1'b1;
        end else if (misaligned) begin
          retire     = 1'b1;
          wbD.regWrt = 1'b0;
          wbD.err    = 1'b1;
        end else begin
          memReq = 1'b1;
          if (memStall) begin
            stallOut = 1'b1;
          end else if (memDone) begin
            retire      = 1'b1;
            wbD.memData = memWrt ? '0 : memRdData;
          end else begin
            stallOut = 1'b1;
            stateD   = WAIT;
            countD   = '0;
          end
        end
      end

      WAIT: begin
        if (memDone) begin
          retire      = 1'b1;
          wbD.memData = memWrt ? '0 : memRdData;
          stateD      = IDLE;
        end else if (countQ == COUNT_LAST) begin
          // Memory never answered: give up and flag the instruction
          retire  = 1'b1;
          wbD.err = 1'b1;
          stateD  = IDLE;
        end else begin
          stallOut = 1'b1;
          countD   = countQ + CNT_W'(1);
        end
      end

      default: begin
        stateD = IDLE;
        countD = '0;
      end
    endcase

    if (rst) begin
      memReq   = 1'b0;
      stallOut = 1'b0;
    end
  end

  assign memWe     = memReq & memWrt;
  assign memAddr   = aluOut;
  assign memWrData = reg2Data;

  mem_wb_reg uMemWb (
    .clk    (clk),
    .rst    (rst),
    .load   (retire),
    .bubble (~retire),
    .d      (wbD),
    .q      (wbQ)
  );

  assign wbRegWrt    = wbQ.regWrt;
  assign wbRegWrtSrc = wbQ.regWrtSrc;
  assign wbWriteReg  = wbQ.writeReg;
  assign wbAluOut    = wbQ.aluOut;
  assign wbMemData   = wbQ.memData;
  assign wbSetVal    = wbQ.setVal;
  assign wbNextPc    = wbQ.nextPc;
  assign wbHalt      = wbQ.halt;
  assign wbErr       = wbQ.err;

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Consumer end of the EX/MEM pipeline register. Takes the execute stage's registered results (ALU result, store data, memory/regfile controls, set value, next PC, halt, err) and performs the data-memory access.
- Handles a stallable data memory through a request/stall/done handshake.
- Stalls upstream while an access is outstanding and drives the MEM/WB pipeline register consumed by writeback.

Parameters:
- TIMEOUT, 64, maximum cycles spent in WAIT before the access is abandoned and flagged as an error.

Ports:
- clk in 1 system clock
- rst in 1 synchronous active-high reset
- aluOut in 16 EX/MEM ALU result; memory address for loads and stores
- reg2Data in 16 EX/MEM store data
- memEn in 1 EX/MEM memory access enable
- memWrt in 1 EX/MEM store (1) or load (0); valid only with memEn
- regWrt in 1 EX/MEM register write enable
- regWrtSrc in 3 EX/MEM writeback source select
- writeReg in 3 EX/MEM destination register
- setVal in 16 EX/MEM set-instruction value
- nextPc in 16 EX/MEM PC+2
- halt in 1 EX/MEM halt
- err in 1 EX/MEM error
- memReq out 1 data-memory request strobe
- memWe out 1 write enable, qualified by memReq
- memAddr out 16 request address
- memWrData out 16 store data
- memRdData in 16 load data, valid with memDone
- memStall in 1 memory cannot accept a request this cycle
- memDone in 1 access complete; may be asserted in the request cycle
- stallOut out 1 hold EX/MEM and all earlier stages this cycle
- wbRegWrt out 1 MEM/WB register write enable
- wbRegWrtSrc out 3 MEM/WB source select
- wbWriteReg out 3 MEM/WB destination register
- wbAluOut out 16 MEM/WB ALU result
- wbMemData out 16 MEM/WB load data
- wbSetVal out 16 MEM/WB set value
- wbNextPc out 16 MEM/WB PC+2
- wbHalt out 1 MEM/WB halt
- wbErr out 1 MEM/WB error

Behaviour:
- Reset: state=IDLE, timeout counter=0, every wb* output=0, memReq=0. Reset during WAIT abandons the access; no request is reissued.
- Misaligned access: memEn & aluOut[0]. No request is issued; the instruction retires next edge with wbErr=1, wbRegWrt=0, wbMemData=0.
- Non-memory instruction (memEn=0): MEM/WB loads the inputs at the next edge (1-cycle latency), wbMemData=0, stallOut=0.
- IDLE with an aligned memEn:
  - memReq=1 combinationally; memWe=memWrt, memAddr=aluOut, memWrData=reg2Data.
  - memStall=1: remain IDLE, stallOut=1, insert a bubble, retry next cycle. Upstream holds its inputs.
  - memStall=0 & memDone=1 (zero-wait): capture memRdData, retire at the edge, stallOut=0.
  - memStall=0 & memDone=0: move to WAIT, counter=0, stallOut=1, insert a bubble.
- WAIT:
  - memReq=0.
  - On memDone: capture memRdData (writes capture 0), retire the instruction, go to IDLE, stallOut=0 that cycle.
  - Otherwise: stallOut=1, bubble, counter+1.
  - counter==TIMEOUT-1 without memDone: retire with wbErr=1, wbMemData=0, go to IDLE.
- Bubble: wbRegWrt=0, wbHalt=0, wbErr=0. Other wb* fields don't-care, driven 0.
- stallOut = (IDLE & memEn & ~aluOut[0] & (memStall | ~memDone)) | (WAIT & ~memDone & ~timeoutHit).
- wbErr = err | misaligned | timeout.
- A halt with memEn is retired only after its access completes.
- memDone while IDLE with no request outstanding is ignored.

Decomposition:
- Package mem_stage_pkg holds:
  - state encoding (IDLE=0, WAIT=1);
  - regWrtSrc encodings shared with writeback;
  - the bubble constant.
- One natural sub-module, mem_wb_reg: the MEM/WB register bank (dff arrays) with load and bubble controls.
- The FSM, counter and handshake logic stay in memory_stage.

Test Plan:
- ALU op, memEn=0, aluOut=16'h1234, regWrt=1, writeReg=3 -> next edge wbAluOut=16'h1234, wbRegWrt=1, wbWriteReg=3, stallOut never 1.
- Zero-wait load: aluOut=16'h0040, memDone=1 in the request cycle, memRdData=16'hBEEF -> memReq for 1 cycle, no stall, next edge wbMemData=16'hBEEF.
- Load with 3-cycle latency -> stallOut high 3 cycles, 3 bubbles (wbRegWrt=0), then wbMemData=returned data, wbRegWrt=1.
- memStall=1 for 2 cycles on a store, reg2Data=16'h00AA -> memReq held 2+ cycles with memWe=1 and memAddr stable; store completes; wbRegWrt=0, wbErr=0.
- Misaligned address 16'h0041 -> no memReq, next edge wbErr=1.
- memDone never asserted with TIMEOUT=64 -> 64 stall cycles, then wbErr=1 and return to IDLE. Separately, rst during WAIT -> all wb*=0 next edge, memReq=0.
